// File: rtl/param_sram.sv
// Single-port synchronous SRAM with per-byte write enables, registered read and
// a clear sequencer that zeroes every word after reset and on request.
module param_sram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7
) (
  input  logic                sram_clk,
  input  logic                sram_ares,
  input  logic                wr_enable,
  input  logic                rd_enable,
  input  logic [DATA_W/8-1:0] byte_en,
  input  logic [ADDR_W-1:0]   ram_index,
  input  logic [DATA_W-1:0]   sram_data_in,
  input  logic                clr_req,
  output logic [DATA_W-1:0]   sram_data_out,
  output logic                rd_valid,
  output logic                busy,
  output logic                access_err
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0]   dout_d;
  logic                rd_valid_d, access_err_d;
  logic                clr_we, usr_we;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   rd_word, merged_word;

  assign rd_word = mem[ram_index];
  assign busy    = (state_q == CLEAR);

  // Write-first view of the addressed word: new bytes where enabled, old elsewhere.
  always_comb begin
    merged_word = rd_word;
    for (int i = 0; i < NB; i++) begin
      if (byte_en[i]) merged_word[8*i +: 8] = sram_data_in[8*i +: 8];
    end
  end

  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    dout_d       = sram_data_out;
    rd_valid_d   = 1'b0;
    access_err_d = 1'b0;
    clr_we       = 1'b0;
    usr_we       = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we       = 1'b1;
        clr_cnt_d    = clr_cnt_q + 1'b1;
        access_err_d = wr_enable | rd_enable;
        if (&clr_cnt_q) state_d = IDLE;
      end
      IDLE: begin
        if (clr_req) begin
          state_d      = CLEAR;
          clr_cnt_d    = '0;
          access_err_d = wr_enable | rd_enable;
        end else begin
          usr_we = wr_enable;
          if (rd_enable) begin
            dout_d     = wr_enable ? merged_word : rd_word;
            rd_valid_d = 1'b1;
          end
        end
      end
      default: begin
        state_d   = CLEAR;
        clr_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge sram_clk or posedge sram_ares) begin
    if (sram_ares) begin
      state_q       <= CLEAR;
      clr_cnt_q     <= '0;
      sram_data_out <= '0;
      rd_valid      <= 1'b0;
      access_err    <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      sram_data_out <= dout_d;
      rd_valid      <= rd_valid_d;
      access_err    <= access_err_d;
    end
  end

  // Storage has no reset; contents become defined once a clear sweep finishes.
  always_ff @(posedge sram_clk) begin
    if (clr_we) begin
      mem[clr_cnt_q] <= '0;
    end else if (usr_we) begin
      for (int i = 0; i < NB; i++) begin
        if (byte_en[i]) mem[ram_index][8*i +: 8] <= sram_data_in[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_param_sram.sv
// Self-checking bench for param_sram (32-bit words, 16 entries) against a
// word-array reference model.
module tb_param_sram;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              sram_clk = 1'b0;
  logic              sram_ares = 1'b1;
  logic              wr_enable, rd_enable, clr_req;
  logic [3:0]        byte_en;
  logic [ADDR_W-1:0] ram_index;
  logic [DATA_W-1:0] sram_data_in;
  logic [DATA_W-1:0] sram_data_out;
  logic              rd_valid, busy, access_err;

  int total = 0;
  int bad   = 0;
  logic [31:0] model [DEPTH];

  param_sram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .sram_clk(sram_clk), .sram_ares(sram_ares), .wr_enable(wr_enable),
    .rd_enable(rd_enable), .byte_en(byte_en), .ram_index(ram_index),
    .sram_data_in(sram_data_in), .clr_req(clr_req), .sram_data_out(sram_data_out),
    .rd_valid(rd_valid), .busy(busy), .access_err(access_err)
  );

  always #5 sram_clk = ~sram_clk;

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  task automatic tick();
    @(posedge sram_clk);
    #1;
  endtask

  task automatic set_in(input logic wr, input logic rd, input logic [3:0] be,
                        input logic [3:0] idx, input logic [31:0] din, input logic clr);
    wr_enable = wr; rd_enable = rd; byte_en = be; ram_index = idx;
    sram_data_in = din; clr_req = clr;
  endtask

  task automatic idle_in();
    set_in(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic zero_model();
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
  endtask

  task automatic test_reset();
    idle_in();
    sram_ares = 1'b1;
    repeat (2) tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b exp=1", busy); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    total++; if (access_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", access_err); end
    total++; if (sram_data_out !== 32'h0) begin bad++; $display("FAIL reset_dout got=%h exp=0", sram_data_out); end
  endtask

  task automatic test_clear_after_reset();
    int n;
    sram_ares = 1'b0;
    wait_idle(n);
    zero_model();
    total++; if (n != DEPTH) begin bad++; $display("FAIL sweep_len got=%0d exp=%0d", n, DEPTH); end
  endtask

  task automatic test_read_all(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b0, 1'b1, 4'h0, 4'(i), 32'h0, 1'b0);
      tick();
      total++;
      if (rd_valid !== 1'b1 || sram_data_out !== model[i]) begin
        bad++;
        $display("FAIL %s_read idx=%0d got=%h/%b exp=%h/1", tag, i, sram_data_out, rd_valid, model[i]);
      end
    end
    idle_in();
    tick();
    total++;
    if (rd_valid !== 1'b0 || sram_data_out !== model[DEPTH-1]) begin
      bad++;
      $display("FAIL %s_hold got=%h/%b exp=%h/0", tag, sram_data_out, rd_valid, model[DEPTH-1]);
    end
  endtask

  task automatic test_byte_write();
    set_in(1'b1, 1'b0, 4'b1111, 4'd5, 32'hDEADBEEF, 1'b0);
    tick();
    model[5] = merge(model[5], 32'hDEADBEEF, 4'b1111);
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL wr_no_valid got=%b exp=0", rd_valid); end
    set_in(1'b1, 1'b0, 4'b0101, 4'd5, 32'h11223344, 1'b0);
    tick();
    model[5] = merge(model[5], 32'h11223344, 4'b0101);
    set_in(1'b1, 1'b0, 4'b0000, 4'd5, 32'hFFFFFFFF, 1'b0);
    tick();
    set_in(1'b0, 1'b1, 4'h0, 4'd5, 32'h0, 1'b0);
    tick();
    idle_in();
    total++;
    if (sram_data_out !== 32'hDE22BE44 || rd_valid !== 1'b1) begin
      bad++; $display("FAIL byte_write got=%h/%b exp=de22be44/1", sram_data_out, rd_valid);
    end
  endtask

  task automatic test_write_first();
    set_in(1'b1, 1'b0, 4'b1111, 4'd3, 32'hAAAAAAAA, 1'b0);
    tick();
    model[3] = 32'hAAAAAAAA;
    set_in(1'b1, 1'b1, 4'b0011, 4'd3, 32'h55555555, 1'b0);
    tick();
    model[3] = merge(model[3], 32'h55555555, 4'b0011);
    total++;
    if (sram_data_out !== 32'hAAAA5555 || rd_valid !== 1'b1) begin
      bad++; $display("FAIL write_first got=%h/%b exp=aaaa5555/1", sram_data_out, rd_valid);
    end
    set_in(1'b0, 1'b1, 4'h0, 4'd3, 32'h0, 1'b0);
    tick();
    idle_in();
    total++;
    if (sram_data_out !== model[3]) begin
      bad++; $display("FAIL write_first_mem got=%h exp=%h", sram_data_out, model[3]);
    end
  endtask

  task automatic test_busy_write();
    int n;
    idle_in();
    sram_ares = 1'b1;
    repeat (2) tick();
    sram_ares = 1'b0;
    set_in(1'b1, 1'b0, 4'hF, 4'd2, 32'hFFFFFFFF, 1'b0);
    tick();
    idle_in();
    total++;
    if (access_err !== 1'b1 || rd_valid !== 1'b0) begin
      bad++; $display("FAIL busy_err got=%b/%b exp=1/0", access_err, rd_valid);
    end
    tick();
    total++; if (access_err !== 1'b0) begin bad++; $display("FAIL busy_err_len got=%b exp=0", access_err); end
    wait_idle(n);
    zero_model();
    total++; if (n != DEPTH - 2) begin bad++; $display("FAIL busy_rest got=%0d exp=%0d", n, DEPTH - 2); end
    set_in(1'b0, 1'b1, 4'h0, 4'd2, 32'h0, 1'b0);
    tick();
    idle_in();
    total++;
    if (sram_data_out !== 32'h0 || rd_valid !== 1'b1) begin
      bad++; $display("FAIL busy_wr_dropped got=%h/%b exp=0/1", sram_data_out, rd_valid);
    end
  endtask

  task automatic test_clr_with_write();
    int n;
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b1, 1'b0, 4'hF, 4'(i), 32'hC0DE0000 + 32'(i), 1'b0);
      tick();
      model[i] = 32'hC0DE0000 + 32'(i);
    end
    set_in(1'b1, 1'b0, 4'hF, 4'd7, 32'h12345678, 1'b1);
    tick();
    idle_in();
    total++;
    if (busy !== 1'b1 || access_err !== 1'b1) begin
      bad++; $display("FAIL clr_wr got busy/err=%b/%b exp=1/1", busy, access_err);
    end
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      clr_req = (n == 3);
      tick();
      n++;
    end
    idle_in();
    zero_model();
    total++; if (n != DEPTH) begin bad++; $display("FAIL clr_len got=%0d exp=%0d", n, DEPTH); end
    test_read_all("clr");
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    set_in(1'b1, 1'b1, 4'hF, 4'd4, 32'h12345678, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 1'b1);
    tick();
    idle_in();
    repeat (9) tick();
    total++;
    if (busy !== 1'b1 || sram_data_out !== 32'h12345678) begin
      bad++; $display("FAIL pre_reset got busy/dout=%b/%h exp=1/12345678", busy, sram_data_out);
    end
    #2 sram_ares = 1'b1;
    #1;
    total++;
    if (sram_data_out !== 32'h0 || busy !== 1'b1 || rd_valid !== 1'b0 || access_err !== 1'b0) begin
      bad++;
      $display("FAIL async_reset got dout/busy/vld/err=%h/%b/%b/%b exp=0/1/0/0",
               sram_data_out, busy, rd_valid, access_err);
    end
    tick();
    sram_ares = 1'b0;
    wait_idle(n);
    zero_model();
    total++; if (n != DEPTH) begin bad++; $display("FAIL restart_len got=%0d exp=%0d", n, DEPTH); end
    test_read_all("rst");
  endtask

  task automatic test_random();
    int busy_left = 0;
    logic [31:0] exp_dout;
    logic exp_valid, exp_err;
    logic wr, rd, clr;
    logic [3:0] be, idx;
    logic [31:0] din;
    exp_dout = sram_data_out;
    for (int c = 0; c < 400; c++) begin
      wr  = 1'($urandom_range(0, 1));
      rd  = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 39) == 0);
      be  = 4'($urandom);
      idx = 4'($urandom);
      din = $urandom;
      set_in(wr, rd, be, idx, din, clr);
      tick();
      exp_valid = 1'b0;
      exp_err   = 1'b0;
      if (busy_left > 0) begin
        exp_err = wr | rd;
        busy_left--;
      end else if (clr) begin
        exp_err   = wr | rd;
        busy_left = DEPTH;
        zero_model();
      end else begin
        if (wr) model[idx] = merge(model[idx], din, be);
        if (rd) begin
          exp_dout  = model[idx];
          exp_valid = 1'b1;
        end
      end
      total++;
      if (sram_data_out !== exp_dout || rd_valid !== exp_valid || access_err !== exp_err ||
          busy !== (busy_left > 0)) begin
        bad++;
        $display("FAIL random c=%0d got dout/vld/err/busy=%h/%b/%b/%b exp=%h/%b/%b/%b",
                 c, sram_data_out, rd_valid, access_err, busy, exp_dout, exp_valid, exp_err,
                 (busy_left > 0));
      end
    end
    idle_in();
  endtask

  initial begin
    test_reset();
    test_clear_after_reset();
    test_read_all("init");
    test_byte_write();
    test_write_first();
    test_busy_write();
    test_clr_with_write();
    test_reset_mid_sweep();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
